// File: rtl/spike_count_binner_if.sv
// Spike binner port bundle: the stimulus side (master) drives spike levels, enable and tick;
// the binner side (slave) returns the latched window results and debug state.
interface spike_count_binner_if #(
  parameter int NUM_CH = 8
);
  logic              en;
  logic [NUM_CH-1:0] spike_in;
  logic              tick;
  logic [31:0]       i_spike_cnt;
  logic              cnt_valid;
  logic [31:0]       total_spikes;
  logic [15:0]       window_len;
  logic              sat_flag;
  logic              running;

  modport master (
    output en, spike_in, tick,
    input  i_spike_cnt, cnt_valid, total_spikes, window_len, sat_flag, running
  );

  modport slave (
    input  en, spike_in, tick,
    output i_spike_cnt, cnt_valid, total_spikes, window_len, sat_flag, running
  );
endinterface

// File: rtl/spike_count_binner.sv
// Counts rising edges on a neuron spike array, bins them into tick-delimited windows,
// and keeps a saturating running total plus a sticky saturation flag.
//
// state | meaning
// IDLE  | after reset, no tick seen yet; counting active, window_len not yet meaningful
// RUN   | at least one tick seen; held until reset
module spike_count_binner #(
  parameter int          NUM_CH  = 8,
  parameter logic [31:0] CNT_MAX = 32'h7FFFFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  spike_count_binner_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_next;
  logic [NUM_CH-1:0] prev;
  logic [NUM_CH-1:0] rise;
  logic [5:0]        pc;
  logic [31:0]       acc;
  logic [32:0]       acc_sum;
  logic [31:0]       acc_next;
  logic              acc_over;
  logic [32:0]       tot_sum;
  logic [31:0]       tot_next;
  logic              tot_over;
  logic [15:0]       cyc;
  logic [15:0]       cyc_inc;
  logic [31:0]       i_spike_cnt_q;
  logic              cnt_valid_q;
  logic [31:0]       total_q;
  logic [15:0]       window_len_q;
  logic              sat_q;

  // prev follows spike_in even while disabled, so toggling en mid-level cannot fake an edge
  assign rise = bus.spike_in & ~prev;

  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rise[i]) pc = pc + 6'd1;
    end
    if (!bus.en) pc = '0;
  end

  always_comb begin
    acc_sum  = {1'b0, acc} + 33'(pc);
    acc_over = acc_sum > {1'b0, CNT_MAX};
    acc_next = acc_over ? CNT_MAX : acc_sum[31:0];
    tot_sum  = {1'b0, total_q} + 33'(pc);
    tot_over = tot_sum > {1'b0, CNT_MAX};
    tot_next = tot_over ? CNT_MAX : tot_sum[31:0];
    cyc_inc  = (cyc == 16'hFFFF) ? cyc : cyc + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.tick) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.running = (state == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev          <= '0;
      acc           <= '0;
      cyc           <= '0;
      i_spike_cnt_q <= '0;
      cnt_valid_q   <= 1'b0;
      total_q       <= '0;
      window_len_q  <= '0;
      sat_q         <= 1'b0;
    end else begin
      prev    <= bus.spike_in;
      total_q <= tot_next;
      if (acc_over || tot_over) sat_q <= 1'b1;
      // rises landing in the tick cycle belong to the window being closed
      if (bus.tick) begin
        i_spike_cnt_q <= acc_next;
        window_len_q  <= cyc_inc;
        cnt_valid_q   <= 1'b1;
        acc           <= '0;
        cyc           <= '0;
      end else begin
        acc         <= acc_next;
        cyc         <= cyc_inc;
        cnt_valid_q <= 1'b0;
      end
    end
  end

  assign bus.i_spike_cnt  = i_spike_cnt_q;
  assign bus.cnt_valid    = cnt_valid_q;
  assign bus.total_spikes = total_q;
  assign bus.window_len   = window_len_q;
  assign bus.sat_flag     = sat_q;

endmodule

// File: tb/tb_spike_count_binner.sv
// Directed bench for spike_count_binner; a small CNT_MAX makes the ceiling reachable quickly.
module tb_spike_count_binner;
  localparam int          NUM_CH  = 8;
  localparam logic [31:0] CNT_MAX = 32'd50;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  spike_count_binner_if #(.NUM_CH(NUM_CH)) bus ();

  spike_count_binner #(.NUM_CH(NUM_CH), .CNT_MAX(CNT_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [NUM_CH-1:0] s, input logic t);
    bus.en       = e;
    bus.spike_in = s;
    bus.tick     = t;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    drive(1'b1, '0, 1'b0);
    step();
    step();
    chk("rst_cnt",     bus.i_spike_cnt,  32'd0);
    chk("rst_valid",   bus.cnt_valid,    32'd0);
    chk("rst_total",   bus.total_spikes, 32'd0);
    chk("rst_wlen",    bus.window_len,   32'd0);
    chk("rst_sat",     bus.sat_flag,     32'd0);
    chk("rst_running", bus.running,      32'd0);
    reset = 1'b0;

    // three single-cycle pulses on ch0, tick on edge 20
    for (int c = 0; c <= 20; c++) begin
      drive(1'b1, (c == 3 || c == 7 || c == 12) ? 8'h01 : 8'h00, c == 20);
      step();
      if (c == 19) chk("t1_valid_pre", bus.cnt_valid, 32'd0);
    end
    chk("t1_cnt",     bus.i_spike_cnt,  32'd3);
    chk("t1_wlen",    bus.window_len,   32'd21);
    chk("t1_valid",   bus.cnt_valid,    32'd1);
    chk("t1_total",   bus.total_spikes, 32'd3);
    chk("t1_running", bus.running,      32'd1);
    drive(1'b1, 8'h00, 1'b0);
    step();
    chk("t1_valid_drop", bus.cnt_valid,   32'd0);
    chk("t1_cnt_hold",   bus.i_spike_cnt, 32'd3);

    // all channels rise on the tick edge
    drive(1'b1, 8'hFF, 1'b1);
    step();
    chk("t2_cnt",   bus.i_spike_cnt,  32'd8);
    chk("t2_wlen",  bus.window_len,   32'd2);
    chk("t2_total", bus.total_spikes, 32'd11);
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 8'h00, c == 4);
      step();
    end
    chk("t2_empty_cnt",   bus.i_spike_cnt,  32'd0);
    chk("t2_empty_wlen",  bus.window_len,   32'd5);
    chk("t2_empty_valid", bus.cnt_valid,    32'd1);

    // ch2 held 10 cycles, en dropped mid-level after an enabled edge
    for (int c = 0; c < 10; c++) begin
      drive((c >= 3 && c < 6) ? 1'b0 : 1'b1, 8'h04, 1'b0);
      step();
    end
    drive(1'b1, 8'h00, 1'b1);
    step();
    chk("t3a_cnt",   bus.i_spike_cnt,  32'd1);
    chk("t3a_wlen",  bus.window_len,   32'd11);
    chk("t3a_total", bus.total_spikes, 32'd12);

    // same level, but en low at the rising edge
    for (int c = 0; c < 10; c++) begin
      drive((c < 2) ? 1'b0 : 1'b1, 8'h04, 1'b0);
      step();
    end
    drive(1'b1, 8'h00, 1'b1);
    step();
    chk("t3b_cnt",   bus.i_spike_cnt,  32'd0);
    chk("t3b_total", bus.total_spikes, 32'd12);

    // two idle cycles, then three back-to-back ticks
    drive(1'b1, 8'h00, 1'b0);
    step();
    step();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'h00, 1'b1);
      step();
      chk("t6_valid", bus.cnt_valid,   32'd1);
      chk("t6_cnt",   bus.i_spike_cnt, 32'd0);
      chk("t6_wlen",  bus.window_len,  (c == 0) ? 32'd3 : 32'd1);
    end
    drive(1'b1, 8'h00, 1'b0);
    step();
    chk("t6_valid_drop", bus.cnt_valid, 32'd0);

    // five spikes then reset mid-window
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, (c % 2 == 0) ? 8'h01 : 8'h00, 1'b0);
      step();
    end
    chk("t5_total_pre", bus.total_spikes, 32'd17);
    #2;
    reset = 1'b1;
    drive(1'b1, 8'h02, 1'b0);
    #1;
    chk("t5_rst_cnt",     bus.i_spike_cnt,  32'd0);
    chk("t5_rst_valid",   bus.cnt_valid,    32'd0);
    chk("t5_rst_total",   bus.total_spikes, 32'd0);
    chk("t5_rst_wlen",    bus.window_len,   32'd0);
    chk("t5_rst_sat",     bus.sat_flag,     32'd0);
    chk("t5_rst_running", bus.running,      32'd0);
    step();
    reset = 1'b0;
    step();
    chk("t5_total_post", bus.total_spikes, 32'd1);
    drive(1'b1, 8'h02, 1'b1);
    step();
    chk("t5_cnt",   bus.i_spike_cnt, 32'd1);
    chk("t5_wlen",  bus.window_len,  32'd2);
    chk("t5_valid", bus.cnt_valid,   32'd1);

    // drive the window and total into the ceiling (CNT_MAX = 50)
    drive(1'b1, 8'h00, 1'b0);
    step();
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 8'hFF, 1'b0);
      step();
      drive(1'b1, 8'h00, 1'b0);
      step();
    end
    chk("t4_sat_pre",   bus.sat_flag,     32'd0);
    chk("t4_total_pre", bus.total_spikes, 32'd49);
    drive(1'b1, 8'hFF, 1'b1);
    step();
    chk("t4_cnt",   bus.i_spike_cnt,  CNT_MAX);
    chk("t4_sat",   bus.sat_flag,     32'd1);
    chk("t4_total", bus.total_spikes, CNT_MAX);
    chk("t4_wlen",  bus.window_len,   32'd14);
    drive(1'b1, 8'h00, 1'b0);
    step();
    drive(1'b1, 8'hFF, 1'b1);
    step();
    chk("t4_cnt_next",   bus.i_spike_cnt,  32'd8);
    chk("t4_sat_sticky", bus.sat_flag,     32'd1);
    chk("t4_total_hold", bus.total_spikes, CNT_MAX);

    drive(1'b0, 8'h00, 1'b1);
    step();
    chk("en_off_tick_cnt", bus.i_spike_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
